// File: rtl/digest_nibble_sequencer_pkg.sv
// Shared hash package: digest word width and the sequencer FSM state type.
package digest_nibble_sequencer_pkg;

    localparam int HASH_WORD_W = 32;
    localparam int HASH_NIBBLES = HASH_WORD_W / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/inverter.sv
// Nibble-order inverter: reverses the order of the nibbles in one hash word,
// e.g. 0x12345678 -> 0x87654321. Purely combinational.
//   data_i : input word
//   data_o : same nibbles in reversed order
module inverter
    import digest_nibble_sequencer_pkg::*;
(
    input  logic [HASH_WORD_W-1:0] data_i,
    output logic [HASH_WORD_W-1:0] data_o
);

    always_comb begin
        data_o = '0;
        for (int n = 0; n < HASH_NIBBLES; n++) begin
            data_o[4*n +: 4] = data_i[4*(HASH_NIBBLES-1-n) +: 4];
        end
    end

endmodule

// File: rtl/digest_nibble_sequencer.sv
// Digest nibble sequencer: snapshots the N-word hash state on start and
// streams it out one nibble-inverted word per valid/ready handshake, then
// pulses done. Starts arriving while a transfer is in flight are dropped and
// recorded in a sticky flag.
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse, digest_in valid in the same cycle
//   digest_in   : N_WORDS x 32-bit hash state, word k at [32k+31:32k]
//   busy        : registered (state != IDLE)
//   out_valid / out_ready / out_data / out_idx / out_last : word stream
//   done        : one-cycle pulse after the final handshake
//   start_drop  : sticky, set by a start that was not accepted
module digest_nibble_sequencer
    import digest_nibble_sequencer_pkg::*;
#(
    parameter int N_WORDS = 8,
    parameter int IDX_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_WORDS*HASH_WORD_W-1:0] digest_in,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [HASH_WORD_W-1:0]         out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_last,
    output logic                           done,
    output logic                           start_drop
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    seq_state_t                               state_q, state_d;
    logic [IDX_W-1:0]                         idx_q, idx_d;
    logic [N_WORDS-1:0][HASH_WORD_W-1:0]      snap_q;
    logic                                     snap_load;
    logic                                     busy_q;
    logic                                     drop_q;
    logic [HASH_WORD_W-1:0]                   word_sel;

    // Next-state logic. In SEND out_valid is 1, so out_ready alone is the
    // handshake; index is cleared on the way back to IDLE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_load = 1'b1;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (snap_load) begin
                snap_q <= digest_in;
            end
            busy_q <= (state_d != IDLE);
            // Any start seen outside IDLE (including the DONE cycle) is lost.
            if (start && (state_q != IDLE)) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Word select by compare loop so the index width need not match the
    // array depth; out-of-range indices cannot occur.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                word_sel = snap_q[k];
            end
        end
    end

    inverter u_inverter (
        .data_i (word_sel),
        .data_o (out_data)
    );

    assign out_valid  = (state_q == SEND);
    assign done       = (state_q == DONE);
    assign out_idx    = idx_q;
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign busy       = busy_q;
    assign start_drop = drop_q;

endmodule

// File: tb/tb_digest_nibble_sequencer.sv
module tb_digest_nibble_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    // 8-word instance
    logic         start;
    logic [255:0] digest_in;
    logic         busy, out_valid, out_ready, out_last, done, start_drop;
    logic [31:0]  out_data;
    logic [3:0]   out_idx;
    // 1-word instance
    logic         start1;
    logic [31:0]  digest1;
    logic         busy1, valid1, ready1, last1, done1, drop1;
    logic [31:0]  data1;
    logic [3:0]   idx1;

    int checks = 0;
    int errors = 0;
    bit drop_model = 1'b0;

    always #5 clk = ~clk;

    digest_nibble_sequencer #(.N_WORDS(8), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .digest_in(digest_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .done(done), .start_drop(start_drop)
    );

    digest_nibble_sequencer #(.N_WORDS(1), .IDX_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .digest_in(digest1),
        .busy(busy1), .out_valid(valid1), .out_ready(ready1),
        .out_data(data1), .out_idx(idx1), .out_last(last1),
        .done(done1), .start_drop(drop1)
    );

    // Reference: peel nibbles off the bottom and push them in from the bottom.
    function automatic logic [31:0] nib_rev(input logic [31:0] x);
        logic [31:0] r = 32'h0;
        for (int n = 0; n < 8; n++) begin
            r = (r << 4) | (x & 32'hF);
            x = x >> 4;
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; digest_in = '0;
        start1 = 1'b0; ready1 = 1'b0; digest1 = '0;
        tick(); tick();
        drop_model = 1'b0;
        checks++; if ({busy, out_valid, out_last, done, start_drop} !== 5'b0)
            begin errors++; $display("FAIL reset flags: got %b want 00000", {busy, out_valid, out_last, done, start_drop}); end
        checks++; if (out_idx !== 4'd0)
            begin errors++; $display("FAIL reset idx: got %0d want 0", out_idx); end
        checks++; if (out_data !== 32'h0)
            begin errors++; $display("FAIL reset data: got %h want 0", out_data); end
        checks++; if ({busy1, valid1, last1, done1, drop1, idx1, data1} !== '0)
            begin errors++; $display("FAIL reset n1: got %h want 0", {busy1, valid1, last1, done1, drop1, idx1, data1}); end
        rst = 1'b0;
    endtask

    // One transfer on the 8-word instance. stall0 = cycles of out_ready low
    // after word 0 appears; rnd = random ready afterwards; drop_at = cycle
    // (relative to start) in which an extra start is injected, 0 for none.
    task automatic test_transfer(input logic [255:0] d, input int stall0,
                                 input bit rnd, input int drop_at, input string nm);
        logic [31:0] expw [8];
        int  exp_idx = 0;
        bit  fin = 1'b0;
        for (int k = 0; k < 8; k++) expw[k] = nib_rev(d[32*k +: 32]);
        digest_in = d; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0; digest_in = rand_digest();
        for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
            if (drop_at > 0 && cyc == drop_at + 1) drop_model = 1'b1;
            checks++; if (start_drop !== drop_model)
                begin errors++; $display("FAIL %s drop c%0d: got %b want %b", nm, cyc, start_drop, drop_model); end
            checks++; if (busy !== 1'b1)
                begin errors++; $display("FAIL %s busy c%0d: got %b want 1", nm, cyc, busy); end
            if (exp_idx < 8) begin
                checks++; if (out_valid !== 1'b1 || done !== 1'b0)
                    begin errors++; $display("FAIL %s valid/done c%0d: got %b%b want 10", nm, cyc, out_valid, done); end
                checks++; if (out_idx !== exp_idx[3:0])
                    begin errors++; $display("FAIL %s idx c%0d: got %0d want %0d", nm, cyc, out_idx, exp_idx); end
                checks++; if (out_data !== expw[exp_idx])
                    begin errors++; $display("FAIL %s data w%0d: got %h want %h", nm, exp_idx, out_data, expw[exp_idx]); end
                checks++; if (out_last !== (exp_idx == 7))
                    begin errors++; $display("FAIL %s last w%0d: got %b want %b", nm, exp_idx, out_last, exp_idx == 7); end
                out_ready = (cyc <= stall0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
                if (out_ready) exp_idx++;
            end else begin
                checks++; if (done !== 1'b1 || out_valid !== 1'b0)
                    begin errors++; $display("FAIL %s done c%0d: got %b%b want 10", nm, cyc, done, out_valid); end
                out_ready = 1'($urandom_range(0, 1));
                fin = 1'b1;
            end
            if (cyc == drop_at) begin start = 1'b1; digest_in = ~d; end
            else start = 1'b0;
            tick();
        end
        start = 1'b0;
        checks++;
        if (!fin) begin
            errors++; $display("FAIL %s timeout: got no done want done", nm);
        end else if ({done, busy, out_valid, start_drop} !== {3'b000, drop_model}) begin
            errors++; $display("FAIL %s idle: got %b want %b", nm, {done, busy, out_valid, start_drop}, {3'b000, drop_model});
        end
    endtask

    task automatic test_stream();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = 32'h1 << (4 * k);
        test_transfer(d, 0, 1'b0, 0, "stream");
    endtask

    task automatic test_stall();
        logic [255:0] d = rand_digest();
        d[31:0] = 32'h12345678;
        test_transfer(d, 5, 1'b0, 0, "stall");
    endtask

    task automatic test_drop_midstream();
        test_transfer(rand_digest(), 0, 1'b0, 3, "drop");
    endtask

    task automatic test_rst_mid();
        logic [255:0] d = rand_digest();
        digest_in = d; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        checks++; if (out_idx !== 4'd4 || out_valid !== 1'b1)
            begin errors++; $display("FAIL rst_mid pre: got idx %0d v %b want 4 1", out_idx, out_valid); end
        rst = 1'b1;
        tick();
        drop_model = 1'b0;
        checks++; if ({busy, out_valid, out_last, done, start_drop, out_idx} !== '0)
            begin errors++; $display("FAIL rst_mid outs: got %b want 0", {busy, out_valid, out_last, done, start_drop, out_idx}); end
        checks++; if (out_data !== 32'h0)
            begin errors++; $display("FAIL rst_mid data: got %h want 0", out_data); end
        rst = 1'b0;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rst_mid nodone: got %b%b want 00", done, busy); end
        test_transfer(rand_digest(), 0, 1'b0, 0, "rst_restart");
    endtask

    task automatic test_done_start();
        logic [255:0] d  = rand_digest();
        logic [255:0] d2 = rand_digest();
        digest_in = d; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        checks++; if (done !== 1'b1)
            begin errors++; $display("FAIL done_start pulse: got %b want 1", done); end
        start = 1'b1; digest_in = ~d;
        tick();
        start = 1'b0;
        drop_model = 1'b1;
        checks++; if ({start_drop, out_valid, busy} !== 3'b100)
            begin errors++; $display("FAIL done_start drop: got %b want 100", {start_drop, out_valid, busy}); end
        start = 1'b1; digest_in = d2;
        tick();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== nib_rev(d2[31:0]))
            begin errors++; $display("FAIL done_start accept: got v%b i%0d %h want v1 i0 %h", out_valid, out_idx, out_data, nib_rev(d2[31:0])); end
        repeat (8) tick();
        checks++; if (done !== 1'b1 || start_drop !== 1'b1)
            begin errors++; $display("FAIL done_start finish: got %b%b want 11", done, start_drop); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) test_transfer(rand_digest(), 0, 1'b1, 0, "b2b");
    endtask

    task automatic test_n1();
        digest1 = 32'hDEADBEEF; start1 = 1'b1; ready1 = 1'b1;
        tick();
        start1 = 1'b0; digest1 = $urandom;
        checks++; if ({valid1, last1, done1, idx1} !== {3'b110, 4'd0} || data1 !== nib_rev(32'hDEADBEEF))
            begin errors++; $display("FAIL n1 word: got %b %h want 1100000 %h", {valid1, last1, done1, idx1}, data1, nib_rev(32'hDEADBEEF)); end
        tick();
        checks++; if ({done1, valid1, busy1} !== 3'b101)
            begin errors++; $display("FAIL n1 done: got %b want 101", {done1, valid1, busy1}); end
        tick();
        checks++; if ({done1, valid1, busy1, drop1} !== 4'b0000)
            begin errors++; $display("FAIL n1 idle: got %b want 0000", {done1, valid1, busy1, drop1}); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_drop_midstream();
        test_rst_mid();
        test_done_start();
        test_back_to_back();
        test_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digest_nibble_sequencer.md
# digest_nibble_sequencer

Controller that sits between the hash core's final-state register and the digest output stream. On a `start` pulse it snapshots the N-word hash state, then emits one word per accepted transfer over a valid/ready interface, routing each word through the existing `inverter` nibble-order block. It asserts a one-cycle `done` after the last word and flags any `start` that arrives while it is busy.

## Interface
- `N_WORDS`, default 8: number of 32-bit digest words per transfer; legal range 1..16.
- `IDX_W`, default 4: width of the word index; must satisfy 2^IDX_W >= N_WORDS.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse; `digest_in` is valid in that same cycle.
- `digest_in` input N_WORDS*32: hash state; word k is `digest_in[32k+31:32k]`.
- `busy` output 1: high from the cycle after an accepted `start` through the `done` cycle.
- `out_valid` output 1: output word available.
- `out_ready` input 1: sink accepts the word.
- `out_data` output 32: nibble-inverted word `out_idx`.
- `out_idx` output IDX_W: index of the word currently presented.
- `out_last` output 1: high while `out_valid` is high and `out_idx == N_WORDS-1`.
- `done` output 1: one-cycle pulse after the final handshake.
- `start_drop` output 1: sticky flag, set by `start` while not IDLE, cleared only by `rst`.

## Operation
- FSM states: IDLE, SEND, DONE.
- IDLE: `start` loads the full `digest_in` into the snapshot register, clears the index to 0, and moves to SEND. Otherwise the FSM stays in IDLE.
- SEND: `out_valid`=1. On `out_valid && out_ready`:
  - if `out_idx == N_WORDS-1`, go to DONE;
  - otherwise increment `out_idx`.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `out_valid`=0.
- `out_data` = `inverter(snapshot[out_idx])`, i.e. the 8 nibbles in reversed order. Example: 0x12345678 becomes 0x87654321.
- `out_data` is driven combinationally from registers only: snapshot plus index, no path from `out_ready`.
- `start` in SEND or DONE:
  - is ignored, and the snapshot is unchanged;
  - sets `start_drop`.
- `start` in the same cycle DONE returns to IDLE is also dropped. A new start is accepted only while the FSM is in IDLE.
- `digest_in` is don't-care outside a `start` cycle.
- Stream rule: once `out_valid` rises, `out_valid`, `out_data`, `out_idx` and `out_last` hold stable until the handshake.
- Stalls of any length are allowed.
- `out_ready` is ignored when `out_valid`=0.
- No index wrap: the index never exceeds N_WORDS-1.

## Timing
- Reset values:
  - state IDLE;
  - `busy`=0, `out_valid`=0, `out_idx`=0, `out_last`=0, `done`=0, `start_drop`=0;
  - `out_data` = inverter(0) = 0, because the snapshot clears to 0.
- `rst` mid-transfer aborts immediately: the FSM is back in IDLE with all outputs at reset values the next cycle, and no `done` is produced.
- `start` at cycle t gives `out_valid`=1 with word 0 at t+1.
- With `out_ready` tied high, word k is presented at t+1+k and `done` pulses at t+1+N_WORDS.
- The minimum start-to-start period is N_WORDS+2 cycles.
- `busy` = (state != IDLE), registered.

## Structure
- Shared hash package holds:
  - the FSM state enum `seq_state_t` {IDLE, SEND, DONE};
  - the constant `HASH_WORD_W` = 32.
- One sub-module instance: the existing `inverter`, placed between the snapshot mux output and `out_data`.
- Everything else lives in a single module: the snapshot register array, the index counter and the FSM.

## Test plan
- Reset, then N_WORDS=8, `start` with word k = 0x0000_0001 << (4k), `out_ready`=1:
  - 8 consecutive words, word k = 0x1000_0000 >> (4k);
  - `out_last` on word 7;
  - `done` at t+9;
  - `busy` high t+1..t+9.
- Word 0 = 0x12345678, with `out_ready` low for 5 cycles:
  - `out_valid`=1 and `out_data`=0x87654321 held for all 5 cycles;
  - `out_idx` stays 0;
  - advance only after `out_ready` goes high.
- `start` at t+3 with a different `digest_in`:
  - the stream is unchanged;
  - `start_drop` rises at t+4 and stays high until `rst`.
- `rst` asserted during word 4:
  - next cycle all outputs are at reset values, with no `done`;
  - a subsequent `start` restarts from word 0 with the new data.
- `start` in the DONE cycle is dropped with `start_drop` set; a `start` issued 1 cycle later is accepted.
- N_WORDS=1, `start` with 0xDEADBEEF:
  - single word 0xFEEBDAED with `out_last`=1;
  - `done` one cycle after the handshake.
